// File: rtl/seq_gen_prog_pkg.sv
// Shared constants, state encoding and width helpers for the programmable sequence generator.
package seq_gen_prog_pkg;

    localparam int unsigned DefWidth = 3;
    localparam int unsigned DefDepth = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_gen_prog_table.sv
// DEPTH x WIDTH sequence register file: resets to the identity pattern, one write port and
// one combinational read port with write-through so a same-edge write is visible to the reader.
module seq_gen_prog_table #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [IW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(i);
            end
        end else if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else if (32'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/seq_gen_prog.sv
// Programmable cyclic sequence generator with registered q output.
// Optional one-shot mode (input oneshot, output done) is enabled by SEQ_GEN_PROG_ONESHOT_EN.
module seq_gen_prog
    import seq_gen_prog_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned IW = idx_width(DEPTH),
    localparam int unsigned LW = len_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [IW-1:0]    load_idx,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             len_wr,
    input  logic [LW-1:0]    len_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             busy
`ifdef SEQ_GEN_PROG_ONESHOT_EN
    ,
    input  logic             oneshot,
    output logic             done
`endif
);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic [WIDTH-1:0] q_q, rd_data;
    logic             wrap_q, wrap_d;
    logic [IW-1:0]    last_idx;
    logic             at_last, len_ok, one_shot;

`ifdef SEQ_GEN_PROG_ONESHOT_EN
    assign one_shot = oneshot;
    assign done     = (state_q == StDone);
`else
    assign one_shot = 1'b0;
`endif

    assign last_idx = IW'(len_q - LW'(1));
    // The last element in the current direction is exactly where a cyclic advance wraps.
    assign at_last  = dir ? (idx_q == '0) : (idx_q == last_idx);
    assign len_ok   = len_wr && (state_q == StIdle) && (len_data != '0) &&
                      (len_data <= LW'(DEPTH));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        if (load) begin
            idx_d = (LW'(load_idx) < len_q) ? load_idx : '0;
        end else if (stop) begin
            state_d = StIdle;
        end else if (start && (state_q != StRun)) begin
            state_d = StRun;
            if (state_q == StDone) begin
                idx_d = dir ? last_idx : '0;
            end
        end else if ((state_q == StRun) && en) begin
            if (at_last && one_shot) begin
                state_d = StDone;
            end else if (at_last) begin
                idx_d  = dir ? last_idx : '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = dir ? (idx_q - IW'(1)) : (idx_q + IW'(1));
            end
        end
        if (len_ok) begin
            len_d = len_data;
            if (LW'(idx_d) >= len_data) begin
                idx_d = '0;
            end
        end
    end

    seq_gen_prog_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk_i   (clk),
        .rst_ni  (clr),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (idx_d),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= LW'(DEPTH);
            q_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            q_q     <= rd_data;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_seq_gen_prog.sv
// Self-checking bench for seq_gen_prog (WIDTH=3, DEPTH=8): directed vector table, reset and
// one-shot sequences, then random stimulus against a behavioural model.
module tb_seq_gen_prog;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0, stop = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [2:0] load_idx = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0, wr_data = '0;
    logic       len_wr = 1'b0;
    logic [3:0] len_data = '0;
    logic       oneshot = 1'b0;
    logic       done;
    logic [2:0] q, qbar, idx;
    logic       wrap, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_gen_prog #(
        .WIDTH (3),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_idx (load_idx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len_wr   (len_wr),
        .len_data (len_data),
        .q        (q),
        .qbar     (qbar),
        .idx      (idx),
        .wrap     (wrap),
        .busy     (busy)
`ifdef SEQ_GEN_PROG_ONESHOT_EN
        ,
        .oneshot  (oneshot),
        .done     (done)
`endif
    );

`ifndef SEQ_GEN_PROG_ONESHOT_EN
    assign done = 1'b0;
`endif

    // Behavioural model: mode 0 = idle, 1 = run, 2 = done.
    int m_tbl[8];
    int m_idx, m_len, m_mode, m_q, m_wrap;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = i;
        m_idx = 0; m_len = 8; m_mode = 0; m_q = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        int nidx = m_idx;
        int nmode = m_mode;
        int w = 0;
        bit last;
        if (load) begin
            nidx = (int'(load_idx) < m_len) ? int'(load_idx) : 0;
        end else if (stop) begin
            nmode = 0;
        end else if (start && m_mode != 1) begin
            nmode = 1;
            if (m_mode == 2) nidx = dir ? m_len - 1 : 0;
        end else if (m_mode == 1 && en) begin
            last = dir ? (m_idx == 0) : (m_idx == m_len - 1);
            if (last && oneshot) begin
                nmode = 2;
            end else begin
                nidx = dir ? (m_idx + m_len - 1) % m_len : (m_idx + 1) % m_len;
                w = last ? 1 : 0;
            end
        end
        if (len_wr && m_mode == 0 && len_data >= 1 && len_data <= 8) begin
            m_len = int'(len_data);
            if (nidx >= m_len) nidx = 0;
        end
        if (wr_en) m_tbl[wr_addr] = int'(wr_data);
        m_idx = nidx; m_mode = nmode; m_wrap = w;
        m_q = m_tbl[m_idx];
    endtask

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"}, 32'(q), m_q);
        check({tag, ".qbar"}, 32'(qbar), 7 - m_q);
        check({tag, ".idx"}, 32'(idx), m_idx);
        check({tag, ".wrap"}, 32'(wrap), m_wrap);
        check({tag, ".busy"}, 32'(busy), (m_mode == 1) ? 1 : 0);
`ifdef SEQ_GEN_PROG_ONESHOT_EN
        check({tag, ".done"}, 32'(done), (m_mode == 2) ? 1 : 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; en = 0; dir = 0; load = 0; load_idx = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; len_wr = 0; len_data = 0;
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b0;
        #1;
        model_reset();
        check({tag, ".q"}, 32'(q), 0);
        check({tag, ".qbar"}, 32'(qbar), 7);
        check({tag, ".idx"}, 32'(idx), 0);
        check({tag, ".wrap"}, 32'(wrap), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    typedef struct {
        logic       start, stop, en, dir, load;
        logic [2:0] load_idx;
        logic       wr_en;
        logic [2:0] wr_addr, wr_data;
        logic       len_wr;
        logic [3:0] len_data;
        int         q, idx, wrap, busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wrap_seen;
        // start stop en dir load lidx | wr addr data | lenwr len | q idx wrap busy
        vecs.push_back('{0,0,0,0,0,0, 1,0,0, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 1,1,4, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 1,2,7, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 1,3,2, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 1,4,3, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 1,5, 0,0,0,0});
        vecs.push_back('{1,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 4,1,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 7,2,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 2,3,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 3,4,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 0,0,1,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 4,1,0,1});
        vecs.push_back('{0,0,0,0,1,0, 0,0,0, 0,0, 0,0,0,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 3,4,1,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 2,3,0,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 7,2,0,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 4,1,0,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 0,0,0,1});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,1});
        vecs.push_back('{0,1,0,0,0,0, 0,0,0, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,1,3, 0,0,0, 0,0, 2,3,0,0});
        vecs.push_back('{0,0,0,0,1,6, 0,0,0, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 1,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 1,9, 0,0,0,0});
        vecs.push_back('{0,0,0,0,1,4, 0,0,0, 0,0, 3,4,0,0});
        vecs.push_back('{1,0,0,0,0,0, 0,0,0, 0,0, 3,4,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 0,0,1,1});
        vecs.push_back('{0,1,1,0,0,0, 0,0,0, 0,0, 0,0,0,0});
        vecs.push_back('{0,0,0,0,1,3, 0,0,0, 0,0, 2,3,0,0});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 1,2, 0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0});
        vecs.push_back('{1,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,1});
        vecs.push_back('{0,0,1,0,0,0, 0,0,0, 0,0, 0,0,1,1});
        vecs.push_back('{0,0,1,0,0,0, 1,0,5, 0,0, 5,0,1,1});
        vecs.push_back('{0,0,1,1,0,0, 0,0,0, 0,0, 5,0,1,1});
        vecs.push_back('{0,0,0,0,0,0, 0,0,0, 0,0, 5,0,0,1});
        vecs.push_back('{0,1,0,0,1,0, 0,0,0, 0,0, 5,0,0,1});
        vecs.push_back('{0,1,0,0,0,0, 0,0,0, 0,0, 5,0,0,0});

        do_reset("reset0");

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; en = vecs[i].en; dir = vecs[i].dir;
            load = vecs[i].load; load_idx = vecs[i].load_idx;
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            len_wr = vecs[i].len_wr; len_data = vecs[i].len_data;
            step();
            check($sformatf("vec%0d.q", i), 32'(q), vecs[i].q);
            check($sformatf("vec%0d.qbar", i), 32'(qbar), 7 - vecs[i].q);
            check($sformatf("vec%0d.idx", i), 32'(idx), vecs[i].idx);
            check($sformatf("vec%0d.wrap", i), 32'(wrap), vecs[i].wrap);
            check($sformatf("vec%0d.busy", i), 32'(busy), vecs[i].busy);
        end
        idle_inputs();

        // Reset mid-run: table writes made while running must be lost.
        do_reset("reset1");
        start = 1; step(); start = 0;
        check_model("run_start");
        en = 1; wr_en = 1; wr_addr = 5; wr_data = 1;
        repeat (3) step();
        wr_en = 0; en = 0;
        check("midrun.q", 32'(q), 3);
        #2;
        clr = 1'b0;
        #1;
        check("async.q", 32'(q), 0);
        check("async.qbar", 32'(qbar), 7);
        check("async.idx", 32'(idx), 0);
        check("async.busy", 32'(busy), 0);
        check("async.wrap", 32'(wrap), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        start = 1; step(); start = 0;
        en = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("ident%0d.q", k), 32'(q), k % 8);
            check($sformatf("ident%0d.wrap", k), 32'(wrap), (k == 8) ? 1 : 0);
            check_model($sformatf("ident%0d", k));
        end
        en = 0;
        stop = 1; step(); stop = 0;

`ifdef SEQ_GEN_PROG_ONESHOT_EN
        begin
            int seq[5] = '{0, 4, 7, 2, 3};
            for (int i = 0; i < 5; i++) begin
                wr_en = 1; wr_addr = 3'(i); wr_data = 3'(seq[i]); step();
            end
            wr_en = 0;
            len_wr = 1; len_data = 5; step(); len_wr = 0;
            oneshot = 1;
            start = 1; step(); start = 0;
            en = 1;
            wrap_seen = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (wrap) wrap_seen = 1;
                check_model($sformatf("oneshot%0d", k));
            end
            check("oneshot.q", 32'(q), 3);
            check("oneshot.done", 32'(done), 1);
            check("oneshot.nowrap", 32'(wrap_seen), 0);
            en = 0;
            start = 1; step(); start = 0;
            check("restart.q", 32'(q), 0);
            en = 1; step(); en = 0;
            check("restart2.q", 32'(q), 4);
            oneshot = 0;
        end
`endif

        for (int n = 0; n < 400; n++) begin
            load = ($urandom_range(0, 15) == 0);
            load_idx = 3'($urandom_range(0, 7));
            stop = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 3'($urandom_range(0, 7));
            len_wr = ($urandom_range(0, 7) == 0);
            len_data = 4'($urandom_range(0, 9));
`ifdef SEQ_GEN_PROG_ONESHOT_EN
            oneshot = ($urandom_range(0, 3) == 0);
`endif
            step();
            check_model($sformatf("rand%0d", n));
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
